spi_reg_ctrl: RTL and testbench

Command/register controller that sequences the byte-level SPI slave datapath. It consumes each received byte, decodes a one-byte command, and reads or writes a small register file with address auto-increment. It preloads the slave's transmit shift register with the response byte for the next transfer. It sits directly behind the SPI slave byte interface and drives the LED and control outputs of the design.

---
 rtl/spi_reg_ctrl.sv | 108 ++++++++++
 tb/tb_spi_reg_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind the SPI slave byte interface.
// Decodes one command byte per frame and reads or writes the register file with auto-increment.
module spi_reg_ctrl #(
  parameter int unsigned NREGS    = 8,
  parameter logic [7:0]  ID_VALUE = 8'h4C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ssel_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       tx_load,
  output logic [7:0] tx_byte,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] ctrl_reg,
  output logic       led,
  output logic [7:0] err_cnt
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0]  WR_ACK = 8'hAC;
  localparam logic [7:0]  ERR_RSP = 8'hEE;

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, ERR} state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [7:0]      regs [NREGS];

  logic [AW-1:0]   cmd_addr;
  logic            cmd_bad;
  logic [7:0]      rd_cmd;
  logic [7:0]      rd_cur;

  // Command decode and read muxes; register 0 is the fixed ID
  assign cmd_addr = rx_byte[AW-1:0];
  assign cmd_bad  = (rx_byte[6:4] != 3'b000) || (5'(rx_byte[3:0]) >= 5'(NREGS));
  assign rd_cmd   = (cmd_addr == '0) ? ID_VALUE : regs[cmd_addr];
  assign rd_cur   = (addr == '0) ? ID_VALUE : regs[addr];

  assign ctrl_reg = regs[1];
  assign led      = regs[1][0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      err_cnt   <= 8'h00;
      tx_load   <= 1'b0;
      tx_byte   <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 4'h0;
      wr_data   <= 8'h00;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= 8'h00;
    end else begin
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      if (!ssel_active) begin
        // Deselect aborts any operation; a coincident byte is dropped
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD: if (rx_valid) begin
            tx_load <= 1'b1;
            if (cmd_bad) begin
              tx_byte <= ERR_RSP;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              state   <= ERR;
            end else if (rx_byte[7]) begin
              addr    <= cmd_addr;
              tx_byte <= WR_ACK;
              state   <= WRITE;
            end else begin
              tx_byte <= rd_cmd;
              addr    <= cmd_addr + AW'(1);
              state   <= READ;
            end
          end
          WRITE: if (rx_valid) begin
            tx_load <= 1'b1;
            tx_byte <= rx_byte;
            addr    <= addr + AW'(1);
            if (addr != '0) begin
              regs[addr] <= rx_byte;
              wr_strobe  <= 1'b1;
              wr_addr    <= 4'(addr);
              wr_data    <= rx_byte;
            end
          end
          READ: if (rx_valid) begin
            tx_load <= 1'b1;
            tx_byte <= rd_cur;
            addr    <= addr + AW'(1);
          end
          ERR: if (rx_valid) begin
            tx_load <= 1'b1;
            tx_byte <= ERR_RSP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl with NREGS=8 and ID 8'h4C.
module tb_spi_reg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ssel_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] ctrl_reg;
  logic       led;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  spi_reg_ctrl #(.NREGS(8), .ID_VALUE(8'h4C)) dut (
    .clk(clk), .rst_n(rst_n), .ssel_active(ssel_active),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_load(tx_load), .tx_byte(tx_byte),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .ctrl_reg(ctrl_reg), .led(led), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One received byte; returns at the negedge where the registered response is visible
  task automatic xfer(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    ssel_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    ssel_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe, wr_addr, wr_data, ctrl_reg, led, err_cnt} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset: load=%b tx=%h wr=%b wa=%h wd=%h ctrl=%h led=%b err=%h, expected all zero",
               tx_load, tx_byte, wr_strobe, wr_addr, wr_data, ctrl_reg, led, err_cnt);
    end
  endtask

  task automatic test_read_id();
    frame_start();
    xfer(8'h00);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe} !== {1'b1, 8'h4C, 1'b0}) begin
      n_fail++; $display("FAIL read_id_cmd: load=%b tx=%h wr=%b, expected 1 4c 0", tx_load, tx_byte, wr_strobe);
    end
    xfer(8'hA7);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL read_id_reg1: load=%b tx=%h wr=%b, expected 1 00 0", tx_load, tx_byte, wr_strobe);
    end
    @(negedge clk);
    n_tests++;
    if (tx_load !== 1'b0 || tx_byte !== 8'h00) begin
      n_fail++; $display("FAIL tx_hold: load=%b tx=%h, expected 0 00", tx_load, tx_byte);
    end
    frame_end();
  endtask

  task automatic test_burst_write();
    frame_start();
    xfer(8'h81);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe} !== {1'b1, 8'hAC, 1'b0}) begin
      n_fail++; $display("FAIL bw_cmd: load=%b tx=%h wr=%b, expected 1 ac 0", tx_load, tx_byte, wr_strobe);
    end
    xfer(8'h01);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe, wr_addr, wr_data, ctrl_reg, led} !== {1'b1, 8'h01, 1'b1, 4'h1, 8'h01, 8'h01, 1'b1}) begin
      n_fail++; $display("FAIL bw_d0: load=%b tx=%h wr=%b wa=%h wd=%h ctrl=%h led=%b, expected 1 01 1 1 01 01 1",
                         tx_load, tx_byte, wr_strobe, wr_addr, wr_data, ctrl_reg, led);
    end
    xfer(8'h55);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe, wr_addr, wr_data} !== {1'b1, 8'h55, 1'b1, 4'h2, 8'h55}) begin
      n_fail++; $display("FAIL bw_d1: load=%b tx=%h wr=%b wa=%h wd=%h, expected 1 55 1 2 55",
                         tx_load, tx_byte, wr_strobe, wr_addr, wr_data);
    end
    frame_end();
    frame_start();
    xfer(8'h02);
    n_tests++;
    if (tx_byte !== 8'h55) begin
      n_fail++; $display("FAIL bw_readback: tx=%h, expected 55", tx_byte);
    end
    frame_end();
  endtask

  task automatic test_wrap();
    frame_start();
    xfer(8'h87);
    xfer(8'h11);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe, wr_addr, wr_data} !== {1'b1, 8'h11, 1'b1, 4'h7, 8'h11}) begin
      n_fail++; $display("FAIL wrap_w7: load=%b tx=%h wr=%b wa=%h wd=%h, expected 1 11 1 7 11",
                         tx_load, tx_byte, wr_strobe, wr_addr, wr_data);
    end
    xfer(8'h22);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe} !== {1'b1, 8'h22, 1'b0}) begin
      n_fail++; $display("FAIL wrap_w0_drop: load=%b tx=%h wr=%b, expected 1 22 0", tx_load, tx_byte, wr_strobe);
    end
    frame_end();
    frame_start();
    xfer(8'h07);
    n_tests++;
    if (tx_byte !== 8'h11) begin
      n_fail++; $display("FAIL wrap_r7: tx=%h, expected 11", tx_byte);
    end
    xfer(8'h00);
    n_tests++;
    if (tx_byte !== 8'h4C) begin
      n_fail++; $display("FAIL wrap_r0: tx=%h, expected 4c", tx_byte);
    end
    frame_end();
    frame_start();
    xfer(8'h00);
    n_tests++;
    if (tx_byte !== 8'h4C) begin
      n_fail++; $display("FAIL reg0_protect: tx=%h, expected 4c", tx_byte);
    end
    frame_end();
  endtask

  task automatic test_invalid();
    frame_start();
    xfer(8'h30);
    n_tests++;
    if ({tx_load, tx_byte, err_cnt} !== {1'b1, 8'hEE, 8'd1}) begin
      n_fail++; $display("FAIL inv_cmd: load=%b tx=%h err=%h, expected 1 ee 01", tx_load, tx_byte, err_cnt);
    end
    xfer(8'hFF);
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe, err_cnt} !== {1'b1, 8'hEE, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL inv_data: load=%b tx=%h wr=%b err=%h, expected 1 ee 0 01",
                         tx_load, tx_byte, wr_strobe, err_cnt);
    end
    frame_end();
    frame_start();
    xfer(8'h88);
    n_tests++;
    if ({tx_byte, err_cnt} !== {8'hEE, 8'd2}) begin
      n_fail++; $display("FAIL inv_addr: tx=%h err=%h, expected ee 02", tx_byte, err_cnt);
    end
    frame_end();
    for (int i = 0; i < 300; i++) begin
      frame_start();
      xfer(8'h30);
      frame_end();
    end
    n_tests++;
    if (err_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL err_sat: err=%h, expected ff", err_cnt);
    end
  endtask

  task automatic test_abort();
    frame_start();
    xfer(8'h82);
    @(negedge clk);
    rx_valid    = 1'b1;
    rx_byte     = 8'h99;
    ssel_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    n_tests++;
    if ({tx_load, wr_strobe, tx_byte} !== {1'b0, 1'b0, 8'hAC}) begin
      n_fail++; $display("FAIL abort: load=%b wr=%b tx=%h, expected 0 0 ac", tx_load, wr_strobe, tx_byte);
    end
    frame_start();
    xfer(8'h02);
    n_tests++;
    if ({tx_load, tx_byte} !== {1'b1, 8'h55}) begin
      n_fail++; $display("FAIL abort_fresh: load=%b tx=%h, expected 1 55", tx_load, tx_byte);
    end
    frame_end();
  endtask

  task automatic test_reset_mid();
    frame_start();
    xfer(8'h81);
    xfer(8'hA5);
    n_tests++;
    if ({ctrl_reg, led, tx_load} !== {8'hA5, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rm_pre: ctrl=%h led=%b load=%b, expected a5 1 1", ctrl_reg, led, tx_load);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tx_load, tx_byte, wr_strobe, wr_addr, wr_data, ctrl_reg, led, err_cnt} !== 39'h0) begin
      n_fail++; $display("FAIL rm_async: load=%b tx=%h wr=%b wa=%h wd=%h ctrl=%h led=%b err=%h, expected all zero",
                         tx_load, tx_byte, wr_strobe, wr_addr, wr_data, ctrl_reg, led, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(8'h02);
    n_tests++;
    if ({tx_load, tx_byte} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL rm_resume: load=%b tx=%h, expected 1 00", tx_load, tx_byte);
    end
    frame_end();
    frame_start();
    xfer(8'h01);
    n_tests++;
    if ({tx_byte, led} !== {8'h00, 1'b0}) begin
      n_fail++; $display("FAIL rm_cold: tx=%h led=%b, expected 00 0", tx_byte, led);
    end
    frame_end();
  endtask

  initial begin
    rst_n       = 1'b1;
    ssel_active = 1'b0;
    rx_valid    = 1'b0;
    rx_byte     = 8'h00;
    #2 rst_n = 1'b0;
    #10;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_read_id();
    test_burst_write();
    test_wrap();
    test_invalid();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
